barrett_reduce_lanes: RTL and testbench

BARRETT_REDUCE_LANES -- requirements
Module: barrett_reduce_lanes

---
 rtl/barrett_pkg.sv | 20 ++
 rtl/barrett_lane.sv | 56 +++++
 rtl/barrett_reduce_lanes.sv | 112 +++++++++++
 tb/tb_barrett_reduce_lanes.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared constants and types for the lane-parallel Barrett reducer.
// The widths the divider uses are derived from K by the modules themselves.
package barrett_pkg;

    localparam int K_DEFAULT  = 32;
    localparam int LATENCY    = 7;
    localparam int DIV_CYCLES = 2 * K_DEFAULT + 1;

    typedef enum logic [1:0] {
        NOMOD = 2'd0,
        DIV   = 2'd1,
        READY = 2'd2
    } state_t;

    // Number of quotient bits in floor(2^(2k)/n) for a k-bit modulus.
    function automatic int div_cycles(input int k);
        return 2 * k + 1;
    endfunction

endpackage

// File: rtl/barrett_lane.sv
// One Barrett reduction lane: seven registered stages from a 2K-bit x to
// x mod n. All lanes share n, mu and the stage enable.
module barrett_lane
    import barrett_pkg::*;
#(
    parameter int K = K_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [K-1:0]     n,
    input  logic [2*K:0]     mu,
    input  logic [2*K-1:0]   x,
    output logic [K-1:0]     r
);

    // Only the low K+2 bits of x matter once the quotient estimate is known.
    logic [K+1:0]   x1, x2, x3, x4;
    logic [K:0]     q1, q3;
    logic [3*K+1:0] q2;
    logic [K+1:0]   p4, t5, r6;
    logic [K+1:0]   n_ext, r7;

    assign n_ext = {2'b00, n};
    assign r7    = (r6 >= n_ext) ? r6 - n_ext : r6;

    // NOTE: pipeline data needs no reset; the valid chain in the top decides
    // which stage contents are meaningful.
    always_ff @(posedge clk) begin
        if (en) begin
            x1 <= x[K+1:0];
            q1 <= x[2*K-1:K-1];
            x2 <= x1;
            q2 <= {{(2*K+1){1'b0}}, q1} * {{(K+1){1'b0}}, mu};
            x3 <= x2;
            q3 <= q2[2*K+1:K+1];
            x4 <= x3;
            p4 <= {1'b0, q3} * n_ext;
            t5 <= x4 - p4;
            r6 <= (t5 >= n_ext) ? t5 - n_ext : t5;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (en) begin
            r <= r7[K-1:0];
        end
    end

    // q3 < 2^(K+1) and r7 < n always, so these bits carry nothing.
    logic unused_bits;
    assign unused_bits = ^{q2[3*K+1:2*K+2], q2[K:0], r7[K+1:K]};

endmodule

// File: rtl/barrett_reduce_lanes.sv
// LANES parallel x mod n reducers sharing one modulus; mu = floor(2^(2K)/n)
// is derived on load by a bit-serial restoring divider.
module barrett_reduce_lanes
    import barrett_pkg::*;
#(
    parameter int K     = K_DEFAULT,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [K-1:0]           cfg_n,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*2*K-1:0]   in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*K-1:0]     out_r
);

    localparam int CNT_W = $clog2(2 * K + 1);

    state_t             state, state_next;
    logic [K-1:0]       n;
    logic [2*K:0]       mu;
    logic [LATENCY-1:0] vld;
    logic [K-1:0]       div_rem;
    logic [CNT_W-1:0]   div_cnt;
    logic [K:0]         trial, rem_next;
    logic               q_bit, div_last;
    logic               cfg_fire, load_ok, in_fire, stage_en;

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign load_ok   = cfg_fire && cfg_n[K-1];
    assign stage_en  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld[LATENCY-1];
    assign div_last  = (div_cnt == '0);

    // Dividend is 2^(2K): only the first bit shifted in is a one.
    assign trial    = {div_rem, div_cnt == CNT_W'(2 * K)};
    assign q_bit    = (trial >= {1'b0, n});
    assign rem_next = q_bit ? trial - {1'b0, n} : trial;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NOMOD;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            NOMOD, READY: if (load_ok)  state_next = DIV;
            DIV:          if (div_last) state_next = READY;
            default:                    state_next = NOMOD;
        endcase
    end

    // A pending modulus load outranks operands.
    always_comb begin
        cfg_ready = (state != DIV) && !(|vld);
        in_ready  = (state == READY) && !(cfg_valid && cfg_ready) && stage_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n       <= '0;
            mu      <= '0;
            cfg_err <= 1'b0;
            vld     <= '0;
        end else begin
            cfg_err <= cfg_fire && !cfg_n[K-1];
            if (load_ok) n <= cfg_n;
            if (state == DIV) mu <= {mu[2*K-1:0], q_bit};
            if (stage_en) vld <= {vld[LATENCY-2:0], in_fire};
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            div_rem <= '0;
            div_cnt <= CNT_W'(2 * K);
        end else if (state == DIV) begin
            div_rem <= rem_next[K-1:0];
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // The partial remainder stays below n, so its top bit is always zero.
    logic unused_rem;
    assign unused_rem = rem_next[K];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        barrett_lane #(.K(K)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (stage_en),
            .n   (n),
            .mu  (mu),
            .x   (in_x[i*2*K +: 2*K]),
            .r   (out_r[i*K +: K])
        );
    end

endmodule

// File: tb/tb_barrett_reduce_lanes.sv
// Self-checking bench for barrett_reduce_lanes (K=32, LANES=4) against a
// plain modulo reference model.
module tb_barrett_reduce_lanes;
    import barrett_pkg::*;

    localparam int K     = 32;
    localparam int LANES = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [K-1:0]           cfg_n;
    logic                   cfg_err;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*2*K-1:0]   in_x;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*K-1:0]     out_r;

    int checks   = 0;
    int failures = 0;
    logic [K-1:0] n_cur;

    barrett_reduce_lanes #(.K(K), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_n     (cfg_n),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    always #5 clk = ~clk;

    function automatic logic [K-1:0] ref_mod(input logic [2*K-1:0] x, input logic [K-1:0] m);
        logic [2*K-1:0] rem;
        rem = x % {32'd0, m};
        return rem[K-1:0];
    endfunction

    function automatic logic [2*K-1:0] rand_lane();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '1;
        if (sel == 1) return '0;
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LANES*2*K-1:0] rand_beat();
        logic [LANES*2*K-1:0] b;
        for (int l = 0; l < LANES; l++) b[l*2*K +: 2*K] = rand_lane();
        return b;
    endfunction

    // Loads a modulus and returns how many cycles the divider stayed busy.
    task automatic load_modulus(input logic [K-1:0] m, output int busy, output logic err_seen);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_n     = m;
        @(negedge clk);
        cfg_valid = 1'b0;
        err_seen  = cfg_err;
        busy      = 0;
        while (dut.state == DIV && busy < 200) begin
            @(negedge clk);
            busy++;
        end
    endtask

    // Presents one beat, returns acceptance, result and latency in cycles.
    task automatic run_beat(input logic [LANES*2*K-1:0] x, output logic acc,
                            output logic [LANES*K-1:0] r, output int lat);
        @(negedge clk);
        in_x      = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 acc = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = out_r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
        checks++; if (out_r !== '0) begin failures++; $display("FAIL reset_out_r got=%h want=0", out_r); end
        checks++; if (dut.state !== NOMOD) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dut.state, NOMOD); end
    endtask

    task automatic test_load();
        int busy;
        logic err;
        n_cur = 32'hFFFF_FFFB;
        load_modulus(n_cur, busy, err);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL load_cfg_err got=%b want=0", err); end
        checks++; if (busy != DIV_CYCLES) begin failures++; $display("FAIL load_div_cycles got=%0d want=%0d", busy, DIV_CYCLES); end
        checks++; if (dut.mu !== 65'h1_0000_0005) begin failures++; $display("FAIL load_mu got=%h want=100000005", dut.mu); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_all_ones();
        logic acc;
        logic [LANES*K-1:0] r;
        int lat;
        run_beat('1, acc, r, lat);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL ones_accept got=%b want=1", acc); end
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL ones_latency got=%0d want=%0d", lat, LATENCY); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (r[l*K +: K] !== 32'h18) begin
                failures++; $display("FAIL ones_lane%0d got=%h want=00000018", l, r[l*K +: K]);
            end
        end
    endtask

    task automatic test_lanes();
        logic acc;
        logic [LANES*K-1:0] r;
        logic [2*K-1:0] nm1;
        logic [K-1:0] want [LANES];
        int lat;
        nm1 = {32'd0, n_cur - 32'd1};
        want[0] = 32'd1; want[1] = 32'd0; want[2] = 32'd0; want[3] = n_cur - 32'd1;
        run_beat({nm1, 32'd0, 32'd0, 32'd0, n_cur, nm1 * nm1}, acc, r, lat);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL lanes_accept got=%b want=1", acc); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (r[l*K +: K] !== want[l]) begin
                failures++; $display("FAIL lanes_lane%0d got=%h want=%h", l, r[l*K +: K], want[l]);
            end
        end
    endtask

    task automatic test_bad_load();
        logic acc;
        logic [LANES*K-1:0] r;
        logic [LANES*2*K-1:0] x;
        int lat;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_n     = 32'h7FFF_FFFF;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bad_in_ready_blocked got=%b want=0", in_ready); end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL bad_cfg_err got=%b want=1", cfg_err); end
        checks++; if (dut.state !== READY) begin failures++; $display("FAIL bad_state got=%0d want=%0d", dut.state, READY); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL bad_cfg_err_pulse got=%b want=0", cfg_err); end
        x = rand_beat();
        run_beat(x, acc, r, lat);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bad_accept got=%b want=1", acc); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (r[l*K +: K] !== ref_mod(x[l*2*K +: 2*K], n_cur)) begin
                failures++; $display("FAIL bad_old_mod_lane%0d got=%h want=%h", l, r[l*K +: K], ref_mod(x[l*2*K +: 2*K], n_cur));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*2*K-1:0] exp_q[$];
        logic [LANES*2*K-1:0] cur, xe;
        logic [LANES*K-1:0] prev_r;
        logic prev_stall, err;
        int sent, got, cyc, busy;
        n_cur = 32'h8000_0000 | $urandom;
        load_modulus(n_cur, busy, err);
        checks++; if (busy != DIV_CYCLES || err !== 1'b0) begin failures++; $display("FAIL b2b_load cycles=%0d err=%b want=%0d/0", busy, err, DIV_CYCLES); end
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_r = '0;
        cur = rand_beat();
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 100);
            in_x      = cur;
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== prev_r) begin
                    failures++; $display("FAIL b2b_hold got=%h/%b want=%h/1", out_r, out_valid, prev_r);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur);
                sent++;
                cur = rand_beat();
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_extra got=%h want=none", out_r);
                end else begin
                    xe = exp_q.pop_front();
                    for (int l = 0; l < LANES; l++) begin
                        checks++;
                        if (out_r[l*K +: K] !== ref_mod(xe[l*2*K +: 2*K], n_cur)) begin
                            failures++; $display("FAIL b2b_beat%0d_lane%0d got=%h want=%h", got, l, out_r[l*K +: K], ref_mod(xe[l*2*K +: 2*K], n_cur));
                        end
                    end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = out_r;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 100) begin failures++; $display("FAIL b2b_count got=%0d want=100", got); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
        repeat (10) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int busy;
        logic err;
        // Reset while the divider is busy.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_n     = 32'hC000_0001;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (dut.state !== DIV) begin failures++; $display("FAIL rdiv_pre_state got=%0d want=%0d", dut.state, DIV); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dut.state !== NOMOD) begin failures++; $display("FAIL rdiv_state got=%0d want=%0d", dut.state, NOMOD); end
        checks++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rdiv_ready got=%b/%b want=1/0", cfg_ready, in_ready); end
        checks++; if (dut.mu !== '0 || dut.n !== '0) begin failures++; $display("FAIL rdiv_nmu got=%h/%h want=0/0", dut.n, dut.mu); end
        @(negedge clk);
        rst = 1'b0;
        // Reset with every stage full and the output stalled.
        n_cur = 32'hC000_0001;
        load_modulus(n_cur, busy, err);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = rand_beat();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rpipe_pre_valid got=%b want=1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rpipe_out_valid got=%b want=0", out_valid); end
        checks++; if (out_r !== '0) begin failures++; $display("FAIL rpipe_out_r got=%h want=0", out_r); end
        checks++; if (dut.state !== NOMOD) begin failures++; $display("FAIL rpipe_state got=%0d want=%0d", dut.state, NOMOD); end
        checks++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rpipe_ready got=%b/%b want=1/0", cfg_ready, in_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rpipe_cfg_err got=%b want=0", cfg_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_n     = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        n_cur     = '0;
        test_reset();
        test_load();
        test_all_ones();
        test_lanes();
        test_bad_load();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
